// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - Command sequencer driving a combinational ALU from an accumulator.
// Optional completed-operation counter output op_count is enabled by defining ALU_SEQ_OPCOUNT_EN.
module alu_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_ctrl,
    input  logic [WIDTH-1:0] cmd_operand,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
`ifdef ALU_SEQ_OPCOUNT_EN
    output logic             res_zero,
    output logic [CNT_W-1:0] op_count
`else
    output logic             res_zero
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_ctrl;
    logic             r_load;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_zero;
    logic             r_res_valid;

    logic             w_accept;
    logic             w_done;
    logic [WIDTH-1:0] w_new_data;
    logic             w_new_zero;

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("alu_cmd_sequencer: WIDTH and CNT_W must be at least 1");
    end

    assign w_accept   = cmd_valid && (r_state == S_IDLE);
    assign w_done     = res_ready && (r_state == S_HOLD);
    assign w_new_data = r_load ? r_b : alu_result;
    assign w_new_zero = r_load ? (r_b == '0) : alu_zero;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_next = S_EXEC;
            S_EXEC:  w_next = S_HOLD;
            S_HOLD:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ALU operands come only from registers, so the ALU sees a stable input for the whole EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_b         <= '0;
            r_ctrl      <= 3'b000;
            r_load      <= 1'b0;
            r_res_data  <= '0;
            r_res_zero  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_b    <= cmd_operand;
                r_ctrl <= cmd_ctrl;
                r_load <= cmd_load;
            end
            if (r_state == S_EXEC) begin
                r_acc       <= w_new_data;
                r_res_data  <= w_new_data;
                r_res_zero  <= w_new_zero;
                r_res_valid <= 1'b1;
            end else if (w_done) begin
                r_res_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_OPCOUNT_EN
    logic [CNT_W-1:0] r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_done) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign op_count = r_op_count;
`endif

    // Gated with rst_n so no command can be taken while reset is held.
    assign cmd_ready = (r_state == S_IDLE) && rst_n;
    assign alu_a     = r_acc;
    assign alu_b     = r_b;
    assign alu_ctrl  = r_ctrl;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_zero  = r_res_zero;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - Self-checking bench for alu_cmd_sequencer with a behavioural ALU and accumulator model.
module tb_alu_cmd_sequencer;

    localparam int W  = 4;
    localparam int CW = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_load = 1'b0;
    logic [2:0]   cmd_ctrl = 3'b000;
    logic [W-1:0] cmd_operand = '0;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [2:0]   alu_ctrl;
    logic [W-1:0] alu_result;
    logic         alu_zero;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic         res_zero;
`ifdef ALU_SEQ_OPCOUNT_EN
    logic [CW-1:0] op_count;
`endif

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_load    (cmd_load),
        .cmd_ctrl    (cmd_ctrl),
        .cmd_operand (cmd_operand),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
`ifdef ALU_SEQ_OPCOUNT_EN
        .res_zero    (res_zero),
        .op_count    (op_count)
`else
        .res_zero    (res_zero)
`endif
    );

    // Stand-in for the combinational ALU instance.
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b010:  alu_result = alu_a + alu_b;
            3'b011:  alu_result = alu_a + ~alu_b + 4'd1;
            default: alu_result = alu_a ^ alu_b;
        endcase
        alu_zero = (alu_result == '0);
    end

    int n_cmp = 0;
    int n_fail = 0;
    int model_acc = 0;
    int exp_cnt = 0;

    function automatic int ref_op(input int acc, input int ctrl, input int op);
        case (ctrl)
            0:       return acc & op;
            1:       return acc | op;
            2:       return (acc + op) % 16;
            3:       return (acc - op + 16) % 16;
            default: return acc ^ op;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input logic ld, input logic [2:0] ctrl, input logic [3:0] op,
                           input int hold, input logic [3:0] exp_d, input logic exp_z);
        logic [3:0] junk;
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_load = ld;
        cmd_ctrl = ctrl;
        cmd_operand = op;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_operand = ~op;
        cmd_ctrl = 3'($urandom);
        cmd_load = ~ld;
        chk("res_valid_exec", {31'd0, res_valid}, 32'd0);
        chk("cmd_ready_exec", {31'd0, cmd_ready}, 32'd0);
        chk("alu_b_exec", {28'd0, alu_b}, {28'd0, op});
        chk("alu_ctrl_exec", {29'd0, alu_ctrl}, {29'd0, ctrl});
        @(posedge clk); #1;
        chk("res_valid_hold", {31'd0, res_valid}, 32'd1);
        chk("res_data", {28'd0, res_data}, {28'd0, exp_d});
        chk("res_zero", {31'd0, res_zero}, {31'd0, exp_z});
        chk("alu_a_new", {28'd0, alu_a}, {28'd0, exp_d});
        for (int i = 0; i < hold; i++) begin
            junk = 4'($urandom);
            cmd_valid = 1'b1;
            cmd_load = 1'b1;
            cmd_operand = junk;
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, res_valid}, 32'd1);
            chk("hold_data", {28'd0, res_data}, {28'd0, exp_d});
            chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        chk("res_valid_done", {31'd0, res_valid}, 32'd0);
        chk("alu_a_done", {28'd0, alu_a}, {28'd0, exp_d});
`ifdef ALU_SEQ_OPCOUNT_EN
        chk("op_count", {30'd0, op_count}, exp_cnt);
`endif
        model_acc = int'(exp_d);
    endtask

    typedef struct {
        logic       ld;
        logic [2:0] ctrl;
        logic [3:0] op;
        int         hold;
        logic [3:0] exp_d;
        logic       exp_z;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic       r_ld;
        logic [2:0] r_ctrl;
        logic [3:0] r_op;
        int         r_exp;

        vecs[0] = '{1'b1, 3'b010, 4'h5, 0, 4'h5, 1'b0};
        vecs[1] = '{1'b0, 3'b010, 4'hC, 0, 4'h1, 1'b0};
        vecs[2] = '{1'b0, 3'b011, 4'h1, 5, 4'h0, 1'b1};
        vecs[3] = '{1'b0, 3'b001, 4'hA, 1, 4'hA, 1'b0};
        vecs[4] = '{1'b0, 3'b000, 4'h3, 0, 4'h2, 1'b0};
        vecs[5] = '{1'b1, 3'b011, 4'h0, 2, 4'h0, 1'b1};
        vecs[6] = '{1'b0, 3'b011, 4'h1, 0, 4'hF, 1'b0};
        vecs[7] = '{1'b0, 3'b010, 4'h1, 0, 4'h0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", {28'd0, res_data}, 32'd0);
        chk("rst_res_zero", {31'd0, res_zero}, 32'd0);
        chk("rst_alu_a", {28'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {28'd0, alu_b}, 32'd0);
        chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].ld, vecs[i].ctrl, vecs[i].op, vecs[i].hold, vecs[i].exp_d, vecs[i].exp_z);
        end

        for (int i = 0; i < 40; i++) begin
            r_ld = ($urandom_range(0, 4) == 0);
            r_ctrl = 3'($urandom_range(0, 3));
            r_op = 4'($urandom);
            r_exp = r_ld ? int'(r_op) : ref_op(model_acc, int'(r_ctrl), int'(r_op));
            run_cmd(r_ld, r_ctrl, r_op, $urandom_range(0, 2), 4'(r_exp), (r_exp == 0));
        end

        run_cmd(1'b1, 3'b000, 4'h9, 0, 4'h9, 1'b0);
        cmd_valid = 1'b1;
        cmd_load = 1'b0;
        cmd_ctrl = 3'b010;
        cmd_operand = 4'h7;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("midrst_alu_a", {28'd0, alu_a}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("midrst_res_data", {28'd0, res_data}, 32'd0);
        chk("midrst_alu_b", {28'd0, alu_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_acc = 0;
        exp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("postrst_res_valid", {31'd0, res_valid}, 32'd0);
            chk("postrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        end
`ifdef ALU_SEQ_OPCOUNT_EN
        chk("postrst_op_count", {30'd0, op_count}, 32'd0);
`endif
        run_cmd(1'b0, 3'b010, 4'h3, 0, 4'h3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            r_op = 4'($urandom);
            run_cmd(1'b1, 3'b000, r_op, 0, r_op, (r_op == 4'h0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the 4-bit ALU interface (A, B, control in; result, zero out).
- Accepts accumulator-style commands over a valid/ready handshake, drives the ALU inputs, captures result and zero into an accumulator, and returns them over a second valid/ready handshake.
- Sits between a command source (test-bench driver or keyboard/typing logic) and the combinational ALU instance.

Parameters:
- WIDTH, 4, datapath width; must equal the ALU width.
- CNT_W, 8, width of the completed-operation counter (optional feature only).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_load  input  1  1: load cmd_operand into accumulator directly, ALU not used
- cmd_ctrl  input  3  ALU control code for this command
- cmd_operand  input  WIDTH  B operand, or load value
- alu_a  output  WIDTH  to ALU A (always the accumulator)
- alu_b  output  WIDTH  to ALU B
- alu_ctrl  output  3  to ALU control
- alu_result  input  WIDTH  from ALU result
- alu_zero  input  1  from ALU zero
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  WIDTH  registered result (equals new accumulator)
- res_zero  output  1  registered zero flag

Behaviour:
- Reset (async, rst_n=0), effective immediately:
  - state=IDLE, accumulator=0, alu_b=0, alu_ctrl=3'b000.
  - res_valid=0, res_data=0, res_zero=0; cmd_ready=0 while rst_n=0.
  - Reset mid-operation discards the command in flight and any pending result.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register cmd_ctrl/cmd_operand/cmd_load, go to EXEC.
  - EXEC: cmd_ready=0. ALU inputs are stable from registers for this whole cycle. At the end of EXEC:
    - cmd_load=0: accumulator<=alu_result, res_data<=alu_result, res_zero<=alu_zero.
    - cmd_load=1: accumulator<=operand, res_data<=operand, res_zero<=(operand==0).
    - Then res_valid<=1 and go to HOLD.
  - HOLD: cmd_ready=0. res_data/res_zero are held stable. On res_ready=1: res_valid<=0, go to IDLE.
- Latency and throughput:
  - Command accepted at edge N gives res_valid=1 after edge N+1.
  - Minimum 3 cycles per command; a back-to-back command is accepted in the cycle after the result handshake.
- alu_a is always the accumulator register; no combinational path from cmd_* to alu_*.
- Arithmetic is mod 2^WIDTH. Overflow and carry-out are not reported; wrap is silent.
- res_ready asserted outside HOLD is ignored. cmd_valid outside IDLE is ignored; the source must hold its command until cmd_ready.
- res_valid never drops without a handshake or reset.
- ALU control codes used in tests: AND 3'b000, OR 3'b001, ADD 3'b010, SUB 3'b011 (control[0]=carry-in).

Optional Feature:
- Macro ALU_SEQ_OPCOUNT_EN.
- When defined: extra output op_count (CNT_W bits), reset to 0.
  - Increments on each result handshake (res_valid&res_ready), including loads.
  - Wraps from 2^CNT_W-1 to 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then load 4'h5 -> res_data=5, res_zero=0, res_valid exactly 2 cycles after accept; alu_a=5 afterwards.
- Acc=5, ADD operand 4'hC -> res_data=4'h1 (wrap), res_zero=0; accumulator=1.
- Acc=1, SUB operand 4'h1 -> res_data=0, res_zero=1.
- res_ready held low 5 cycles in HOLD -> res_valid/res_data stable, cmd_ready=0, new cmd_valid ignored.
- Assert rst_n=0 during EXEC -> res_valid=0, accumulator=0 immediately; no stale result after release.
- ALU_SEQ_OPCOUNT_EN defined, CNT_W=2, 5 commands -> op_count sequence 1,2,3,0,1.
